wb_loader: RTL and testbench
============================

# wb_loader

Wishbone initiator that turns a byte-serial command stream into single 32-bit Wishbone transactions against `wb_system`'s backdoor port, returning status and read data on a byte-serial response stream. Sits between a host link (UART/SPI byte interface) and `wb_system`. It is used to load ROM images and inspect or patch RAM and status while the CPU runs. One transaction is outstanding at a time; there is no pipelining on the bus side.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `wb_strobe_o` is held without `wb_ack_i` (only with the timeout feature enabled).

Ports:
- `clock` input 1: single clock domain; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cmd_data_i` input 8: command byte.
- `cmd_valid_i` input 1: command byte is valid.
- `cmd_ready_o` output 1: loader accepts a byte this cycle.
- `rsp_data_o` output 8: response byte.
- `rsp_valid_o` output 1: response byte is valid.
- `rsp_ready_i` input 1: host consumes the response byte.
- `wb_addr_o` output 32: Wishbone address, passed through unmodified (bits [17:16] select ROM/RAM region in `wb_system`).
- `wb_data_o` output 32: Wishbone write data.
- `wb_data_i` input 32: Wishbone read data.
- `wb_cyc_o` output 1: Wishbone cycle.
- `wb_strobe_o` output 1: Wishbone strobe.
- `wb_we_o` output 1: Wishbone write enable.
- `wb_ack_i` input 1: Wishbone acknowledge.
- `busy_o` output 1: high in any state other than IDLE.

## Operation
- Byte transfer rule:
  - A command byte transfers on any edge where `cmd_valid_i & cmd_ready_o`.
  - A response byte transfers on any edge where `rsp_valid_o & rsp_ready_i`.
- Frame format:
  - Opcode byte: `0x57` write, `0x52` read.
  - Then 4 address bytes, MSB first.
  - Write frames follow with 4 data bytes, MSB first.
- Response format:
  - One status byte: `0x00` ok, `0xEE` timeout, `0xFF` bad opcode.
  - Read frames (ok or timeout) follow with 4 data bytes, MSB first. Data is `0x00000000` on timeout.
  - Bad opcode produces the single status byte only, with no bus cycle.
- State machine:
  - IDLE: accept opcode. `0x57`/`0x52` -> ADDR, latching `we`. Any other value -> RSP_STATUS with status `0xFF`.
  - ADDR: accept 4 bytes into the address shift register. After byte 4: write -> DATA, read -> BUS.
  - DATA: accept 4 bytes into the write-data register. After byte 4 -> BUS.
  - BUS: `wb_cyc_o = wb_strobe_o = 1`, `wb_we_o = we`. On the edge that samples `wb_ack_i = 1`:
    - drop cyc/strobe/we;
    - capture `wb_data_i` if read;
    - set status `0x00`;
    - go to RSP_STATUS.
  - RSP_STATUS: present status. On transfer: read frame with ok/timeout -> RSP_DATA; otherwise -> IDLE.
  - RSP_DATA: present 4 data bytes MSB first, then -> IDLE.
- `cmd_ready_o` is decoded from state: 1 exactly in IDLE, ADDR and DATA.
- `rsp_valid_o` is decoded from state: 1 exactly in RSP_STATUS and RSP_DATA.
- Byte counter is 2 bits. It is cleared on every state entry and wraps only via state change.
- `wb_addr_o` and `wb_data_o` hold their last values after the cycle ends. They are only updated in ADDR/DATA.

## Timing
- Reset values:
  - All outputs 0, except `cmd_ready_o = 1` (state IDLE).
  - Internal registers and counters 0.
  - Reset mid-cycle drops `wb_cyc_o`/`wb_strobe_o` immediately (asynchronously) and discards any partial frame.
- Bus start: if the last command byte transfers at edge N, cyc/strobe are high from edge N through the edge that samples ack.
- Zero-wait responder (ack at edge N+1):
  - cyc/strobe are high for exactly one cycle;
  - `rsp_valid_o` rises at edge N+1.
- Ack is ignored outside BUS. Acks arriving while idle or in response states have no effect.
- The response stream stalls indefinitely while `rsp_ready_i = 0`, and no new command is accepted meanwhile.

## Configuration
- `WB_LOADER_TIMEOUT_EN` defined:
  - An 8+-bit counter (width fits `TIMEOUT_CYCLES`) clears on BUS entry and increments each BUS cycle without ack.
  - On the edge where the count equals `TIMEOUT_CYCLES` with no ack: drop cyc/strobe, set status `0xEE`, go to RSP_STATUS.
  - If ack and timeout coincide, ack wins (status `0x00`, data captured).
- `WB_LOADER_TIMEOUT_EN` undefined: no counter; BUS waits for ack forever, and `0xEE` is never produced.

## Test plan
- Write `57 00 00 00 10 DE AD BE EF`, responder acks after 2 wait cycles -> one Wishbone write with addr `0x00000010`, data `0xDEADBEEF`, `we=1`, cyc high 3 cycles; response `00`.
- Read `52 00 01 02 04`, responder returns `0x0000000A` with zero wait -> cyc high 1 cycle, `we=0`; response `00 00 00 00 0A`.
- Bad opcode `41` -> no cyc; response `FF`; the next valid write frame completes normally.
- With `WB_LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, read with no ack -> strobe high exactly 4 cycles then low; response `EE 00 00 00 00`. Same stimulus with ack arriving on cycle 4 -> status `00` and data captured.
- Random `cmd_valid_i`/`rsp_ready_i` back-pressure over 100 mixed frames -> responses match a reference model byte for byte; `cmd_ready_o` stays 0 while the response is pending.
- Assert `reset_n` mid-BUS -> cyc/strobe low in the same cycle; after release `busy_o = 0` and the next frame completes.

Source files
------------

// File: rtl/wb_loader.sv
// Byte-serial command stream to single 32-bit Wishbone transactions, with byte-serial status/data responses.
// Optional bus timeout: define WB_LOADER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module wb_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  cmd_data_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    input  logic [31:0] wb_data_i,
    output logic        wb_cyc_o,
    output logic        wb_strobe_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    output logic        busy_o
);

    // state        | meaning
    // S_IDLE       | waiting for opcode byte
    // S_ADDR       | shifting in 4 address bytes, MSB first
    // S_DATA       | shifting in 4 write-data bytes, MSB first
    // S_BUS        | Wishbone cycle in flight, waiting for ack
    // S_RSP_STATUS | presenting status byte
    // S_RSP_DATA   | presenting 4 read-data bytes, MSB first
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ADDR       = 3'd1,
        S_DATA       = 3'd2,
        S_BUS        = 3'd3,
        S_RSP_STATUS = 3'd4,
        S_RSP_DATA   = 3'd5
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_BADOP = 8'hFF;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  status_q, status_d;
    logic        cmd_fire;
    logic        rsp_fire;
    logic        in_bus;

    assign in_bus      = (state_q == S_BUS);
    assign cmd_ready_o = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rsp_valid_o = (state_q == S_RSP_STATUS) || (state_q == S_RSP_DATA);
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;
    assign rsp_fire    = rsp_valid_o & rsp_ready_i;

    // Bus strobes decode straight from state so an async reset drops them at once.
    assign wb_cyc_o    = in_bus;
    assign wb_strobe_o = in_bus;
    assign wb_we_o     = in_bus & we_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign busy_o      = (state_q != S_IDLE);

`ifdef WB_LOADER_TIMEOUT_EN
    localparam logic [7:0] ST_TIMEOUT = 8'hEE;
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    always_comb begin
        tmo_d = '0;
        if (in_bus && !wb_ack_i) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign tmo_hit = in_bus && !wb_ack_i && (tmo_d == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_data_i == OP_WRITE) begin
                        we_d    = 1'b1;
                        state_d = S_ADDR;
                    end else if (cmd_data_i == OP_READ) begin
                        we_d    = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        status_d = ST_BADOP;
                        state_d  = S_RSP_STATUS;
                    end
                end
            end
            S_ADDR: begin
                if (cmd_fire) begin
                    addr_d = {addr_q[23:0], cmd_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = we_q ? S_DATA : S_BUS;
                    end
                end
            end
            S_DATA: begin
                if (cmd_fire) begin
                    wdata_d = {wdata_q[23:0], cmd_data_i};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (wb_ack_i) begin
                    if (!we_q) begin
                        rdata_d = wb_data_i;
                    end
                    status_d = ST_OK;
                    state_d  = S_RSP_STATUS;
                end
`ifdef WB_LOADER_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_d  = '0;
                    status_d = ST_TIMEOUT;
                    state_d  = S_RSP_STATUS;
                end
`endif
            end
            S_RSP_STATUS: begin
                // Read frames carry data after an ok or timeout status; bad opcodes never do.
                if (rsp_fire) begin
                    state_d = (!we_q && status_q != ST_BADOP) ? S_RSP_DATA : S_IDLE;
                end
            end
            S_RSP_DATA: begin
                if (rsp_fire) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        rsp_data_o = 8'h00;
        if (state_q == S_RSP_STATUS) begin
            rsp_data_o = status_q;
        end else if (state_q == S_RSP_DATA) begin
            case (cnt_q)
                2'd0:    rsp_data_o = rdata_q[31:24];
                2'd1:    rsp_data_o = rdata_q[23:16];
                2'd2:    rsp_data_o = rdata_q[15:8];
                default: rsp_data_o = rdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_wb_loader.sv
// Testbench for wb_loader: directed frame table, stall/stray-ack and reset sequences, optional timeout
// sequences, and randomized back-pressure against a frame-level reference model.
module tb_wb_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  cmd_data_i = 8'h00;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i = 32'h0;
    logic        wb_cyc_o;
    logic        wb_strobe_o;
    logic        wb_we_o;
    logic        wb_ack_i = 1'b0;
    logic        busy_o;

    wb_loader #(.TIMEOUT_CYCLES(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cmd_data_i  (cmd_data_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_data_i   (wb_data_i),
        .wb_cyc_o    (wb_cyc_o),
        .wb_strobe_o (wb_strobe_o),
        .wb_we_o     (wb_we_o),
        .wb_ack_i    (wb_ack_i),
        .busy_o      (busy_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", name);
    endtask

    // Responder memory; unwritten words read back as a fixed function of the address.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] backing(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hC0FFEE00);
    endfunction

    int          ack_wait = 0;
    bit          ack_en = 1'b1;
    bit          stray_ack = 1'b0;
    int          cyc_cnt = 0;
    int          last_len = 0;
    int          bus_count = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic        last_we = 1'b0;

    always @(negedge clock) begin
        if (wb_cyc_o && wb_strobe_o) begin
            cyc_cnt++;
            if (ack_en && cyc_cnt > ack_wait) begin
                wb_ack_i   = 1'b1;
                last_addr  = wb_addr_o;
                last_we    = wb_we_o;
                last_wdata = wb_data_o;
                wb_data_i  = wb_we_o ? 32'h0 : backing(wb_addr_o);
                if (wb_we_o) mem[wb_addr_o] = wb_data_o;
                bus_count++;
            end else begin
                wb_ack_i = 1'b0;
            end
        end else begin
            if (cyc_cnt != 0) last_len = cyc_cnt;
            cyc_cnt   = 0;
            wb_ack_i  = stray_ack;
            wb_data_i = 32'hBAD0BAD0;
        end
    end

    logic [7:0] rx[$];
    int ready_pct = 100;
    int valid_pct = 100;

    always @(negedge clock) begin
        rsp_ready_i = ($urandom_range(0, 99) < ready_pct);
        if (rsp_valid_o && rsp_ready_i) begin
            rx.push_back(rsp_data_o);
            chk("cmd_ready_during_rsp", {31'b0, cmd_ready_o}, 32'h0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        int guard = 0;
        while (!done && guard < 3000) begin
            @(negedge clock);
            guard++;
            if ($urandom_range(0, 99) < valid_pct) begin
                cmd_valid_i = 1'b1;
                cmd_data_i  = b;
                if (cmd_ready_o) done = 1'b1;
            end else begin
                cmd_valid_i = 1'b0;
                cmd_data_i  = 8'($urandom);
            end
        end
        if (!done) fail("cmd_accept");
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        send_byte(op);
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        end
        if (op == 8'h57) begin
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
        end
        @(negedge clock);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int bound);
        int g = 0;
        while (rx.size() < n && g < bound) begin
            @(negedge clock);
            g++;
        end
        if (rx.size() < n) fail("rsp_bytes");
        repeat (2) @(negedge clock);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_c;
        int          exp_len;
        logic [7:0]  exp_status;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // Frame-level reference model for the random phase.
    logic [31:0] ref_mem [logic [31:0]];
    logic [7:0]  exp_q[$];

    initial begin
        int bc0;
        int nexp;
        logic [31:0] got;

        vecs[0] = '{8'h57, 32'h00000010, 32'hDEADBEEF, 2, 3, 8'h00, 32'h0};
        vecs[1] = '{8'h52, 32'h00010204, 32'h0,        0, 1, 8'h00, 32'h0000000A};
        vecs[2] = '{8'h41, 32'h0,        32'h0,        0, 0, 8'hFF, 32'h0};
        vecs[3] = '{8'h57, 32'h00020000, 32'h12345678, 1, 2, 8'h00, 32'h0};
        vecs[4] = '{8'h52, 32'h00000010, 32'h0,        1, 2, 8'h00, 32'hDEADBEEF};
        mem[32'h00010204] = 32'h0000000A;

        #12;
        chk("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
        chk("rst_rsp_data", {24'b0, rsp_data_o}, 32'h0);
        chk("rst_cyc_stb_we", {29'b0, wb_cyc_o, wb_strobe_o, wb_we_o}, 32'h0);
        chk("rst_addr", wb_addr_o, 32'h0);
        chk("rst_wdata", wb_data_o, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        foreach (vecs[k]) begin
            rx.delete();
            ack_wait = vecs[k].wait_c;
            bc0 = bus_count;
            send_frame(vecs[k].op, vecs[k].addr, vecs[k].wdata);
            nexp = (vecs[k].op == 8'h52) ? 5 : 1;
            wait_rx(nexp, 200);
            chk($sformatf("v%0d_rsp_count", k), rx.size(), nexp);
            if (rx.size() >= 1) chk($sformatf("v%0d_status", k), {24'b0, rx[0]}, {24'b0, vecs[k].exp_status});
            if (nexp == 5 && rx.size() >= 5) begin
                got = {rx[1], rx[2], rx[3], rx[4]};
                chk($sformatf("v%0d_rdata", k), got, vecs[k].exp_rdata);
            end
            if (vecs[k].exp_len == 0) begin
                chk($sformatf("v%0d_no_bus", k), bus_count - bc0, 0);
            end else begin
                chk($sformatf("v%0d_bus_count", k), bus_count - bc0, 1);
                chk($sformatf("v%0d_cyc_len", k), last_len, vecs[k].exp_len);
                chk($sformatf("v%0d_addr", k), last_addr, vecs[k].addr);
                chk($sformatf("v%0d_we", k), {31'b0, last_we}, {31'b0, vecs[k].op == 8'h57});
                chk($sformatf("v%0d_addr_hold", k), wb_addr_o, vecs[k].addr);
                if (vecs[k].op == 8'h57) chk($sformatf("v%0d_wdata", k), last_wdata, vecs[k].wdata);
            end
            chk($sformatf("v%0d_idle", k), {31'b0, busy_o}, 32'h0);
        end

        // Stray acks while idle, then a stalled response under stray acks.
        stray_ack = 1'b1;
        repeat (4) @(negedge clock);
        chk("stray_idle_busy", {31'b0, busy_o}, 32'h0);
        chk("stray_idle_rsp", {31'b0, rsp_valid_o}, 32'h0);
        stray_ack = 1'b0;
        rx.delete();
        ready_pct = 0;
        ack_wait = 0;
        send_frame(8'h57, 32'h00000020, 32'h0BADF00D);
        repeat (20) @(negedge clock);
        stray_ack = 1'b1;
        repeat (5) @(negedge clock);
        stray_ack = 1'b0;
        chk("stall_rsp_valid", {31'b0, rsp_valid_o}, 32'h1);
        chk("stall_cmd_ready", {31'b0, cmd_ready_o}, 32'h0);
        chk("stall_rsp_data", {24'b0, rsp_data_o}, 32'h0);
        chk("stall_bytes", rx.size(), 0);
        ready_pct = 100;
        wait_rx(1, 50);
        chk("stall_release_count", rx.size(), 1);
        chk("stall_release_idle", {31'b0, busy_o}, 32'h0);

        // Reset in the middle of a bus cycle.
        rx.delete();
        ack_en = 1'b0;
        send_frame(8'h52, 32'h00000100, 32'h0);
        begin
            int g = 0;
            while (!wb_cyc_o && g < 50) begin
                @(negedge clock);
                g++;
            end
            if (!wb_cyc_o) fail("reset_bus_entry");
        end
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'h0);
        chk("mid_rst_stb", {31'b0, wb_strobe_o}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", {31'b0, busy_o}, 32'h0);
        chk("post_rst_no_rsp", rx.size(), 0);
        send_frame(8'h57, 32'h00000044, 32'hCAFEF00D);
        wait_rx(1, 200);
        send_frame(8'h52, 32'h00000044, 32'h0);
        wait_rx(6, 200);
        if (rx.size() >= 6) begin
            chk("post_rst_wr_status", {24'b0, rx[0]}, 32'h0);
            chk("post_rst_rd_status", {24'b0, rx[1]}, 32'h0);
            got = {rx[2], rx[3], rx[4], rx[5]};
            chk("post_rst_rd_data", got, 32'hCAFEF00D);
        end

`ifdef WB_LOADER_TIMEOUT_EN
        rx.delete();
        ack_en = 1'b0;
        send_frame(8'h52, 32'h00000200, 32'h0);
        wait_rx(5, 200);
        chk("tmo_len", last_len, 4);
        if (rx.size() >= 5) begin
            chk("tmo_status", {24'b0, rx[0]}, 32'hEE);
            got = {rx[1], rx[2], rx[3], rx[4]};
            chk("tmo_data", got, 32'h0);
        end
        rx.delete();
        ack_en = 1'b1;
        ack_wait = 3;
        send_frame(8'h52, 32'h00000204, 32'h0);
        wait_rx(5, 200);
        chk("tmo_ack_len", last_len, 4);
        if (rx.size() >= 5) begin
            chk("tmo_ack_status", {24'b0, rx[0]}, 32'h0);
            got = {rx[1], rx[2], rx[3], rx[4]};
            chk("tmo_ack_data", got, 32'h00000204 ^ 32'hC0FFEE00);
        end
`endif

        // Randomized mixed frames with back-pressure on both streams.
        mem.delete();
        ref_mem.delete();
        rx.delete();
        exp_q.delete();
        valid_pct = 70;
        ready_pct = 60;
        for (int f = 0; f < 100; f++) begin
            int kind;
            logic [7:0]  op;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] w;
            kind = $urandom_range(0, 9);
            a = (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 7)) << 2);
            d = $urandom;
            if (kind < 4) begin
                op = 8'h57;
                ref_mem[a] = d;
                exp_q.push_back(8'h00);
            end else if (kind < 8) begin
                op = 8'h52;
                w = ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hC0FFEE00);
                exp_q.push_back(8'h00);
                for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
            end else begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                exp_q.push_back(8'hFF);
            end
            ack_wait = $urandom_range(0, 3);
            send_frame(op, a, d);
        end
        wait_rx(exp_q.size(), 3000);
        chk("rand_rsp_count", rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
            chk($sformatf("rand_byte%0d", i), {24'b0, rx[i]}, {24'b0, exp_q[i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
